// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the time/date set editor.
// Field limits are kept here so the editor and any future display logic agree.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_COMMIT
  } edit_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int HOUR_MIN  = 0;
  localparam int HOUR_MAX  = 23;
  localparam int MIN_MIN   = 0;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MIN   = 0;
  localparam int SEC_MAX   = 59;
  localparam int DAY_MIN   = 1;
  localparam int DAY_MAX   = 31;
  localparam int MONTH_MIN = 1;
  localparam int MONTH_MAX = 12;
  localparam int YEAR_MIN  = 0;
  localparam int YEAR_MAX  = 9999;

  localparam logic [23:0] RESET_TIME = 24'h000000;
  localparam logic [31:0] RESET_DATE = 32'h01012024;

  function automatic int bcd_to_int(input logic [15:0] bcd);
    return int'(bcd[15:12]) * 1000 + int'(bcd[11:8]) * 100 +
           int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    bcd_digit_t d3, d2, d1, d0;
    d3 = bcd_digit_t'((v / 1000) % 10);
    d2 = bcd_digit_t'((v / 100) % 10);
    d1 = bcd_digit_t'((v / 10) % 10);
    d0 = bcd_digit_t'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [7:0] int_to_bcd2(input int v);
    bcd_digit_t d1, d0;
    d1 = bcd_digit_t'((v / 10) % 10);
    d0 = bcd_digit_t'(v % 10);
    return {d1, d0};
  endfunction

  // One step up or down inside [lo, hi], wrapping at either end.
  function automatic logic [15:0] bcd_step(input logic [15:0] bcd, input int lo,
                                           input int hi, input logic up);
    int v;
    v = bcd_to_int(bcd);
    if (up) v = (v >= hi) ? lo : v + 1;
    else    v = (v <= lo) ? hi : v - 1;
    return int_to_bcd(v);
  endfunction

  function automatic int days_in_month(input logic [7:0] month, input logic [15:0] year);
    int m, y;
    m = bcd_to_int({8'h00, month});
    y = bcd_to_int(year);
    case (m)
      2: return (((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default: return 31;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw active-low pushbutton, debounces it, and emits a single
// one-cycle pulse for each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic butt,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1, sync2, stable, stable_d;
  logic [CW-1:0] cnt;

  // Internally 1 means pressed; the accepted level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= ~butt;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// Button-driven editor for clock time or date: snapshots the live value,
// lets the user step three fields in BCD, then commits with a load strobe.
module time_set_editor
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_mode,
  input  logic        butt_change,
  input  logic        butt_increase,
  input  logic        butt_decrease,
  input  logic [23:0] cur_time,
  input  logic [31:0] cur_date,
  output logic [23:0] set_time,
  output logic [31:0] set_date,
  output logic        load_time,
  output logic        load_date,
  output logic        editing,
  output logic [1:0]  edit_field
);

  edit_state_t state, state_next;
  logic        chg_p, inc_p, dec_p;
  logic        mode, step_en, day_over;
  logic [23:0] shadow_time;
  logic [31:0] shadow_date;
  logic [15:0] field_val, field_new;
  logic [7:0]  dim_bcd;
  int          field_lo, field_hi, dim;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_change (
    .clk(clk), .rst(rst), .butt(butt_change), .press(chg_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .butt(butt_increase), .press(inc_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst(rst), .butt(butt_decrease), .press(dec_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    editing    = 1'b0;
    edit_field = 2'd0;
    load_time  = 1'b0;
    load_date  = 1'b0;
    unique case (state)
      ST_IDLE: if (chg_p) state_next = ST_F1;
      ST_F1: begin
        editing    = 1'b1;
        edit_field = 2'd1;
        if (chg_p) state_next = ST_F2;
      end
      ST_F2: begin
        editing    = 1'b1;
        edit_field = 2'd2;
        if (chg_p) state_next = ST_F3;
      end
      ST_F3: begin
        editing    = 1'b1;
        edit_field = 2'd3;
        if (chg_p) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        load_time  = ~mode;
        load_date  = mode;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    field_val = '0;
    field_lo  = 0;
    field_hi  = 0;
    case ({mode, edit_field})
      3'b0_01: begin field_val = {8'h00, shadow_time[23:16]}; field_lo = HOUR_MIN;  field_hi = HOUR_MAX;  end
      3'b0_10: begin field_val = {8'h00, shadow_time[15:8]};  field_lo = MIN_MIN;   field_hi = MIN_MAX;   end
      3'b0_11: begin field_val = {8'h00, shadow_time[7:0]};   field_lo = SEC_MIN;   field_hi = SEC_MAX;   end
      3'b1_01: begin field_val = {8'h00, shadow_date[31:24]}; field_lo = DAY_MIN;   field_hi = DAY_MAX;   end
      3'b1_10: begin field_val = {8'h00, shadow_date[23:16]}; field_lo = MONTH_MIN; field_hi = MONTH_MAX; end
      3'b1_11: begin field_val = shadow_date[15:0];           field_lo = YEAR_MIN;  field_hi = YEAR_MAX;  end
      default: ;
    endcase
    field_new = bcd_step(field_val, field_lo, field_hi, inc_p);
    dim       = days_in_month(shadow_date[23:16], shadow_date[15:0]);
    dim_bcd   = int_to_bcd2(dim);
    day_over  = bcd_to_int({8'h00, shadow_date[31:24]}) > dim;
  end

  // A change press wins over inc/dec; opposing inc and dec cancel.
  assign step_en = editing && !chg_p && (inc_p ^ dec_p);

  // Day clamp is applied on the F3->COMMIT edge so set_date is final during the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_time <= RESET_TIME;
      shadow_date <= RESET_DATE;
      mode        <= 1'b0;
    end else if (state == ST_IDLE && chg_p) begin
      shadow_time <= cur_time;
      shadow_date <= cur_date;
      mode        <= sw_mode;
    end else if (step_en) begin
      case ({mode, edit_field})
        3'b0_01: shadow_time[23:16] <= field_new[7:0];
        3'b0_10: shadow_time[15:8]  <= field_new[7:0];
        3'b0_11: shadow_time[7:0]   <= field_new[7:0];
        3'b1_01: shadow_date[31:24] <= field_new[7:0];
        3'b1_10: shadow_date[23:16] <= field_new[7:0];
        3'b1_11: shadow_date[15:0]  <= field_new;
        default: ;
      endcase
    end else if (state == ST_F3 && chg_p && mode && day_over) begin
      shadow_date[31:24] <= dim_bcd;
    end
  end

  assign set_time = shadow_time;
  assign set_date = shadow_date;

endmodule

// File: tb/tb_time_set_editor.sv
// Self-checking bench for time_set_editor: directed scenarios plus random
// edit sessions compared against an integer-field reference model.
module tb_time_set_editor;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, sw_mode, butt_change, butt_increase, butt_decrease;
  logic [23:0] cur_time, set_time;
  logic [31:0] cur_date, set_date;
  logic        load_time, load_date, editing;
  logic [1:0]  edit_field;

  int vectors = 0;
  int miscompares = 0;

  // model: fields are {hour, min, sec, day, month, year}
  int m_state, m_mode;
  int m_f[6];
  int c_f[6];
  int lo[6] = '{0, 0, 0, 1, 1, 0};
  int hi[6] = '{23, 59, 59, 31, 12, 9999};
  int exp_lt_cnt = 0, exp_ld_cnt = 0, lt_cnt = 0, ld_cnt = 0;
  logic [23:0] exp_cap_time, cap_time;
  logic [31:0] exp_cap_date, cap_date;

  always #10 clk = ~clk;

  time_set_editor #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw_mode(sw_mode),
    .butt_change(butt_change), .butt_increase(butt_increase), .butt_decrease(butt_decrease),
    .cur_time(cur_time), .cur_date(cur_date), .set_time(set_time), .set_date(set_date),
    .load_time(load_time), .load_date(load_date), .editing(editing), .edit_field(edit_field));

  always @(negedge clk) begin
    if (load_time) begin lt_cnt++; cap_time = set_time; end
    if (load_date) begin ld_cnt++; cap_date = set_date; end
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] b2(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [15:0] b4(input int v);
    logic [7:0] a, b;
    a = b2(v / 100);
    b = b2(v % 100);
    return {a, b};
  endfunction

  function automatic logic [23:0] pack_t(input int h, input int m, input int s);
    return {b2(h), b2(m), b2(s)};
  endfunction

  function automatic logic [31:0] pack_d(input int d, input int mo, input int y);
    return {b2(d), b2(mo), b4(y)};
  endfunction

  function automatic int mdl_dim(input int mo, input int y);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit leap;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2 && leap) return 29;
    return len[mo-1];
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_mode  = 0;
    m_f     = '{0, 0, 0, 1, 1, 2024};
  endtask

  task automatic set_cur();
    cur_time = pack_t(c_f[0], c_f[1], c_f[2]);
    cur_date = pack_d(c_f[3], c_f[4], c_f[5]);
  endtask

  task automatic model_apply(input bit chg, input bit inc, input bit dec);
    int idx, n;
    if (chg) begin
      if (m_state == 0) begin
        m_f = c_f; m_mode = int'(sw_mode); m_state = 1;
      end else if (m_state < 3) begin
        m_state++;
      end else begin
        if (m_mode == 1 && m_f[3] > mdl_dim(m_f[4], m_f[5])) m_f[3] = mdl_dim(m_f[4], m_f[5]);
        if (m_mode == 1) begin exp_ld_cnt++; exp_cap_date = pack_d(m_f[3], m_f[4], m_f[5]); end
        else begin exp_lt_cnt++; exp_cap_time = pack_t(m_f[0], m_f[1], m_f[2]); end
        m_state = 0;
      end
    end else if (m_state != 0 && (inc ^ dec)) begin
      idx = m_mode * 3 + m_state - 1;
      n = hi[idx] - lo[idx] + 1;
      m_f[idx] = lo[idx] + ((m_f[idx] - lo[idx] + (inc ? 1 : n - 1)) % n);
    end
  endtask

  task automatic press(input bit chg, input bit inc, input bit dec);
    @(posedge clk); #1;
    butt_change = !chg; butt_increase = !inc; butt_decrease = !dec;
    repeat (D + 6) @(posedge clk);
    #1;
    butt_change = 1'b1; butt_increase = 1'b1; butt_decrease = 1'b1;
    repeat (D + 6) @(posedge clk);
    #1;
    model_apply(chg, inc, dec);
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1; sw_mode = 1'b0;
    butt_change = 1'b0; butt_increase = 1'b1; butt_decrease = 1'b1;
    c_f = '{12, 34, 56, 15, 6, 2020}; set_cur();
    model_reset();
    repeat (3) @(posedge clk); #1;
    vectors++; if (set_time !== 24'h000000) begin miscompares++; $display("FAIL reset_set_time: got %h expected 000000", set_time); end
    vectors++; if (set_date !== 32'h01012024) begin miscompares++; $display("FAIL reset_set_date: got %h expected 01012024", set_date); end
    vectors++; if ({editing, edit_field, load_time, load_date} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got ed=%b f=%0d lt=%b ld=%b expected all 0", editing, edit_field, load_time, load_date); end
    rst = 1'b0;
    pulses = 0;
    repeat (D) begin @(posedge clk); #1; if (dut.u_db_change.press) pulses++; end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset_held_button: got %0d pulses expected 0", pulses); end
    rst = 1'b1; butt_change = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (D + 6) @(posedge clk); #1;
  endtask

  task automatic test_debounce();
    int pulses, first_at;
    pulses = 0;
    @(posedge clk); #1; butt_increase = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 3) butt_increase = 1'b1;
      if (dut.u_db_inc.press) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL glitch_pulse: got %0d pulses expected 0", pulses); end
    pulses = 0; first_at = -1;
    @(posedge clk); #1; butt_increase = 1'b0;
    for (int k = 1; k <= 2 * D + 8; k++) begin
      @(posedge clk); #1;
      if (dut.u_db_inc.press) begin pulses++; if (first_at < 0) first_at = k; end
    end
    butt_increase = 1'b1;
    repeat (D + 6) @(posedge clk); #1;
    model_apply(1'b0, 1'b1, 1'b0);
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL held_pulse_count: got %0d expected 1", pulses); end
    vectors++; if (first_at !== D + 3) begin miscompares++; $display("FAIL pulse_latency: got %0d expected %0d", first_at, D + 3); end
    vectors++; if (set_time !== pack_t(m_f[0], m_f[1], m_f[2]) || editing !== 1'b0) begin
      miscompares++; $display("FAIL idle_inc_ignored: got %h ed=%b expected %h ed=0", set_time, editing, pack_t(m_f[0], m_f[1], m_f[2])); end
  endtask

  task automatic test_time_edit();
    sw_mode = 1'b0;
    c_f = '{23, 59, 58, 15, 6, 2023}; set_cur();
    press(1, 0, 0);
    vectors++; if (editing !== 1'b1 || edit_field !== 2'd1) begin miscompares++; $display("FAIL time_enter_f1: got ed=%b f=%0d expected 1/1", editing, edit_field); end
    press(0, 1, 0);
    vectors++; if (set_time !== 24'h005958) begin miscompares++; $display("FAIL time_hour_wrap: got %h expected 005958", set_time); end
    press(1, 0, 0); press(0, 0, 1);
    vectors++; if (set_time !== 24'h005858) begin miscompares++; $display("FAIL time_min_dec: got %h expected 005858", set_time); end
    press(1, 0, 0); press(0, 1, 0); press(0, 1, 0);
    vectors++; if (set_time !== 24'h005800 || edit_field !== 2'd3) begin miscompares++; $display("FAIL time_sec_wrap: got %h f=%0d expected 005800 f=3", set_time, edit_field); end
    press(1, 0, 0);
    vectors++; if (lt_cnt !== exp_lt_cnt || ld_cnt !== exp_ld_cnt) begin
      miscompares++; $display("FAIL time_load_count: got lt=%0d ld=%0d expected lt=%0d ld=%0d", lt_cnt, ld_cnt, exp_lt_cnt, exp_ld_cnt); end
    vectors++; if (cap_time !== 24'h005800) begin miscompares++; $display("FAIL time_commit_value: got %h expected 005800", cap_time); end
    vectors++; if (editing !== 1'b0 || edit_field !== 2'd0) begin miscompares++; $display("FAIL time_back_idle: got ed=%b f=%0d expected 0/0", editing, edit_field); end
  endtask

  task automatic test_date_clamp();
    sw_mode = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      c_f = '{8, 0, 0, 31, 1, (pass == 0) ? 2023 : 2024}; set_cur();
      press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
      vectors++; if (set_date[23:16] !== 8'h02) begin miscompares++; $display("FAIL date_month_inc: got %h expected 02", set_date[23:16]); end
      press(1, 0, 0); press(1, 0, 0);
      vectors++; if (ld_cnt !== exp_ld_cnt || lt_cnt !== exp_lt_cnt) begin
        miscompares++; $display("FAIL date_load_count: got ld=%0d lt=%0d expected ld=%0d lt=%0d", ld_cnt, lt_cnt, exp_ld_cnt, exp_lt_cnt); end
      vectors++; if (cap_date !== ((pass == 0) ? 32'h28022023 : 32'h29022024)) begin
        miscompares++; $display("FAIL date_clamp_%0d: got %h expected %h", pass, cap_date, (pass == 0) ? 32'h28022023 : 32'h29022024); end
    end
  endtask

  task automatic test_year_wrap();
    sw_mode = 1'b1;
    c_f = '{0, 0, 0, 15, 6, 9999}; set_cur();
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
    vectors++; if (set_date[15:0] !== 16'h0000) begin miscompares++; $display("FAIL year_inc_wrap: got %h expected 0000", set_date[15:0]); end
    press(0, 0, 1);
    vectors++; if (set_date[15:0] !== 16'h9999) begin miscompares++; $display("FAIL year_dec_wrap: got %h expected 9999", set_date[15:0]); end
    press(1, 0, 0);
    vectors++; if (cap_date !== 32'h15069999 || ld_cnt !== exp_ld_cnt) begin
      miscompares++; $display("FAIL year_commit: got %h cnt=%0d expected 15069999 cnt=%0d", cap_date, ld_cnt, exp_ld_cnt); end
  endtask

  task automatic test_simultaneous();
    sw_mode = 1'b0;
    c_f = '{10, 20, 30, 1, 1, 2000}; set_cur();
    press(1, 0, 0); press(0, 1, 1);
    vectors++; if (set_time !== 24'h102030 || edit_field !== 2'd1) begin
      miscompares++; $display("FAIL inc_dec_cancel: got %h f=%0d expected 102030 f=1", set_time, edit_field); end
    press(1, 1, 0);
    vectors++; if (set_time !== 24'h102030 || edit_field !== 2'd2) begin
      miscompares++; $display("FAIL change_beats_inc: got %h f=%0d expected 102030 f=2", set_time, edit_field); end
    press(1, 0, 0); press(1, 0, 0);
    vectors++; if (cap_time !== 24'h102030 || lt_cnt !== exp_lt_cnt) begin
      miscompares++; $display("FAIL simult_commit: got %h cnt=%0d expected 102030 cnt=%0d", cap_time, lt_cnt, exp_lt_cnt); end
  endtask

  task automatic test_reset_mid_edit();
    sw_mode = 1'b0;
    c_f = '{5, 6, 7, 2, 3, 2001}; set_cur();
    press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
    vectors++; if (edit_field !== 2'd2 || set_time !== 24'h050707) begin
      miscompares++; $display("FAIL pre_reset_f2: got f=%0d %h expected f=2 050707", edit_field, set_time); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    vectors++; if (editing !== 1'b0 || edit_field !== 2'd0 || set_time !== 24'h000000) begin
      miscompares++; $display("FAIL mid_edit_reset: got ed=%b f=%0d %h expected 0/0 000000", editing, edit_field, set_time); end
    rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    vectors++; if (lt_cnt !== exp_lt_cnt || ld_cnt !== exp_ld_cnt || editing !== 1'b0) begin
      miscompares++; $display("FAIL no_load_after_reset: got lt=%0d ld=%0d ed=%b expected lt=%0d ld=%0d ed=0", lt_cnt, ld_cnt, editing, exp_lt_cnt, exp_ld_cnt); end
  endtask

  task automatic test_random();
    int ops, r;
    for (int s = 0; s < 10; s++) begin
      sw_mode = 1'($urandom_range(0, 1));
      c_f = '{$urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
              $urandom_range(1, 31), $urandom_range(1, 12), $urandom_range(0, 9999)};
      set_cur();
      press(1, 0, 0);
      sw_mode = 1'($urandom_range(0, 1));
      for (int f = 0; f < 3; f++) begin
        ops = $urandom_range(0, 3);
        for (int o = 0; o < ops; o++) begin
          r = $urandom_range(0, 3);
          press(0, r == 0 || r == 2, r == 1 || r == 2);
          vectors++; if (set_time !== pack_t(m_f[0], m_f[1], m_f[2]) || set_date !== pack_d(m_f[3], m_f[4], m_f[5]) ||
                         edit_field !== 2'(m_state)) begin
            miscompares++; $display("FAIL random_step s=%0d: got %h %h f=%0d expected %h %h f=%0d", s, set_time, set_date, edit_field,
                                    pack_t(m_f[0], m_f[1], m_f[2]), pack_d(m_f[3], m_f[4], m_f[5]), m_state); end
        end
        press(1, 1'($urandom_range(0, 1)), 1'b0);
      end
      vectors++; if (lt_cnt !== exp_lt_cnt || ld_cnt !== exp_ld_cnt) begin
        miscompares++; $display("FAIL random_load_count s=%0d: got lt=%0d ld=%0d expected lt=%0d ld=%0d", s, lt_cnt, ld_cnt, exp_lt_cnt, exp_ld_cnt); end
      vectors++; if (cap_time !== exp_cap_time || cap_date !== exp_cap_date) begin
        miscompares++; $display("FAIL random_commit s=%0d: got %h %h expected %h %h", s, cap_time, cap_date, exp_cap_time, exp_cap_date); end
    end
  endtask

  initial begin
    rst = 1'b1; sw_mode = 1'b0;
    butt_change = 1'b1; butt_increase = 1'b1; butt_decrease = 1'b1;
    cur_time = '0; cur_date = '0;
    exp_cap_time = '0; exp_cap_date = '0; cap_time = '0; cap_date = '0;
    test_reset();
    test_debounce();
    test_time_edit();
    test_date_clamp();
    test_year_wrap();
    test_simultaneous();
    test_reset_mid_edit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_set_editor.md
TIME_SET_EDITOR -- requirements
Module: time_set_editor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), meaning stable-input cycles required before a button state is accepted.
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sw_mode  input  1  0 = edit time, 1 = edit date.
REQ-005 SHALL have ports butt_change, butt_increase, butt_decrease  input  1 each  raw, unsynchronised, active-low pushbuttons.
REQ-006 SHALL have port cur_time  input  24  live BCD {h1,h0,m1,m0,s1,s0}.
REQ-007 SHALL have port cur_date  input  32  live BCD {d1,d0,mo1,mo0,y3,y2,y1,y0}.
REQ-008 SHALL have port set_time  output  24  edited time, BCD, same packing as cur_time.
REQ-009 SHALL have port set_date  output  32  edited date, BCD, same packing as cur_date.
REQ-010 SHALL have ports load_time, load_date  output  1 each  one-cycle commit strobes.
REQ-011 SHALL have port editing  output  1  high while any edit state is active.
REQ-012 SHALL have port edit_field  output  2  field being edited: 0 none, 1 hour/day, 2 min/month, 3 sec/year.

Function
REQ-013 SHALL pass each button through a 2-FF synchroniser, then a debounce counter that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 SHALL emit a one-cycle press pulse on each accepted released->pressed transition; no pulse on release; a held button gives exactly one pulse.
REQ-015 SHALL run FSM IDLE -> F1 -> F2 -> F3 -> COMMIT -> IDLE, advancing one state per change pulse; COMMIT lasts one cycle and advances without a pulse.
REQ-016 SHALL, on IDLE->F1, copy cur_time and cur_date into shadow registers and latch sw_mode; sw_mode changes during an edit are ignored.
REQ-017 SHALL drive set_time/set_date from the shadow registers continuously.
REQ-018 SHALL, in F1..F3, add +1 per increment pulse and -1 per decrement pulse to the selected field, in BCD with wrap.
REQ-019 SHALL apply these field ranges: hour 00-23, minute 00-59, second 00-59, day 01-31, month 01-12, year 0000-9999; increment above max gives min; decrement below min gives max.
REQ-020 SHALL, in COMMIT, clamp day to the length of the month (Feb 28, or 29 in a leap year: divisible by 4 and not by 100, or divisible by 400; Apr/Jun/Sep/Nov 30) before the strobe.
REQ-021 SHALL assert load_time (time mode) or load_date (date mode) for exactly the COMMIT cycle, with set_* already final in that cycle.
REQ-022 SHALL ignore simultaneous increment and decrement pulses (no change).
REQ-023 SHALL, when a change pulse coincides with an inc/dec pulse, advance state and drop the inc/dec.
REQ-024 SHALL ignore inc/dec pulses in IDLE and COMMIT.
REQ-025 SHALL set editing = 1 in F1..F3 and edit_field = 1/2/3 in F1/F2/F3, otherwise 0.

Reset
REQ-026 SHALL, while rst = 1, force FSM to IDLE, debounce state to released, counters to 0, shadow time 00:00:00, shadow date 01-01-2024, load strobes 0, editing 0, edit_field 0.
REQ-027 SHALL abandon an edit when reset occurs mid-edit, with no load strobe.
REQ-028 SHALL emit no press pulse during the first DEBOUNCE_CYCLES cycles after reset release, even if a button is held.

Structure
REQ-029 SHALL place the FSM state enum, field min/max constants and the BCD digit typedef in a shared package, clock_pkg.
REQ-030 SHALL implement debounce and edge detection as the sub-module button_debounce, instantiated three times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-031 SHALL check that a 3-cycle low glitch on butt_increase produces no pulse, and that a sustained press produces exactly one pulse, DEBOUNCE_CYCLES+3 cycles after the edge.
REQ-032 SHALL check, with time mode and cur_time 23:59:58: change, inc (hour -> 00), change, dec (min -> 58), change, inc x2 (sec -> 00), change -> load_time for one cycle with set_time 00:58:00.
REQ-033 SHALL check, with date mode and 31-01-2023: change, change, inc (month -> 02), change, change -> load_date with set_date 28-02-2023; the same sequence with year 2024 gives 29-02-2024.
REQ-034 SHALL check year 9999 + inc -> 0000 and 0000 + dec -> 9999.
REQ-035 SHALL check that simultaneous inc and dec pulses leave the field unchanged, and that change coincident with inc advances the field without incrementing.
REQ-036 SHALL check that asserting rst in F2 returns to IDLE with editing 0, and that no load strobe fires then or later.
